median_filter_conf_host: RTL and testbench
==========================================

MEDIAN_FILTER_CONF_HOST -- requirements
Module: median_filter_conf_host

Interface
REQ-001 Parameters SHALL be:
- DW_MA, 8, bus address width.
- DW_MD, 16, bus data width.
- TIMEOUT, 15, maximum cycles to wait for m_mb_val.
- INIT_EN, 1, enables the boot write sequence.
- INIT_IW, 640, boot image width.
- INIT_IH, 480, boot image height.
REQ-002 Ports SHALL be:
- clk, input, 1, single clock.
- rstb, input, 1, reset; synchronous, active-high.
- cmd_valid, input, 1, host command valid.
- cmd_ready, output, 1, host command accepted.
- cmd_wr, input, 1, 1 = write, 0 = read.
- cmd_adr, input, DW_MA, register address.
- cmd_wdt, input, DW_MD, write data.
- rsp_valid, output, 1, response valid.
- rsp_ready, input, 1, host takes response.
- rsp_rdt, output, DW_MD, read data (0 for writes).
- rsp_err, output, 1, transaction timed out.
- m_mb_adr, output, DW_MA, bus address.
- m_mb_wdt, output, DW_MD, bus write data.
- m_mb_wr, output, 1, one-cycle write strobe.
- m_mb_rd, output, 1, one-cycle read strobe.
- m_mb_rdt, input, DW_MD, responder read data.
- m_mb_val, input, 1, responder acknowledge.
- init_done, output, 1, boot sequence finished.
- boot_err, output, 1, sticky: a boot write timed out.

Function
REQ-003 FSM states SHALL be BOOT, IDLE, REQ, WAIT, RESP; exactly one transaction SHALL be outstanding at a time.
REQ-004 BOOT (entered from reset when INIT_EN=1) SHALL issue three writes in order:
- adr 1 <- INIT_IW
- adr 2 <- INIT_IH
- adr 0 <- 16'h0001
Each write SHALL use the REQ/WAIT path and SHALL produce no rsp_valid.
REQ-005 After the third boot write completes or times out: init_done SHALL go 1 and the FSM SHALL enter IDLE. With INIT_EN=0, reset SHALL go directly to IDLE with init_done=1 on the first post-reset cycle.
REQ-006 cmd_ready SHALL be 1 only in IDLE. A command SHALL be captured on the cycle cmd_valid and cmd_ready are both 1, and the FSM SHALL go to REQ.
REQ-007 REQ SHALL last exactly one cycle:
- m_mb_adr and m_mb_wdt driven from the captured command.
- m_mb_wr = cmd_wr, m_mb_rd = ~cmd_wr.
- Next state WAIT.
REQ-008 m_mb_adr and m_mb_wdt SHALL hold their values through WAIT. m_mb_wr and m_mb_rd SHALL be 0 outside REQ.
REQ-009 WAIT SHALL:
- Increment a counter from 0 each cycle.
- On m_mb_val=1, capture m_mb_rdt (reads only, else 0), clear err, go to RESP (or the next BOOT step).
- If the counter reaches TIMEOUT with no m_mb_val, set err, set rdt=0, and leave the same way.
REQ-010 m_mb_val in the same cycle as the strobe (REQ) SHALL be accepted as the acknowledge, giving zero-wait completion.
REQ-011 m_mb_val seen in IDLE, BOOT-between-steps or RESP SHALL be ignored.
REQ-012 RESP SHALL hold rsp_valid, rsp_rdt and rsp_err stable until rsp_ready=1, then return to IDLE. cmd_ready SHALL stay 0 in that handoff cycle.
REQ-013 Minimum command-to-response latency SHALL be 3 cycles: capture, REQ, first WAIT cycle with val, then rsp_valid. Timeout latency SHALL be TIMEOUT+2 cycles.
REQ-014 boot_err SHALL be set by any boot-write timeout and cleared only by reset. Host-command timeouts SHALL NOT affect boot_err.

Reset
REQ-015 On rstb=1 at a clk edge, the following SHALL be 0:
- cmd_ready, rsp_valid, rsp_rdt, rsp_err
- m_mb_adr, m_mb_wdt, m_mb_wr, m_mb_rd
- init_done, boot_err, the timeout counter
The state SHALL be BOOT (INIT_EN=1) or IDLE (INIT_EN=0).
REQ-016 Reset mid-transaction SHALL abandon it with no response. The boot sequence SHALL restart from adr 1.

Verification
REQ-017 Boot, responder acks each strobe after 2 cycles -> strobes (1,640), (2,480), (0,1) in order; init_done=1 one cycle after the third ack; boot_err=0.
REQ-018 Write cmd adr=2, wdt=0x01E0, zero-wait ack -> m_mb_wr pulses once in the cycle after acceptance; rsp_valid 3 cycles after acceptance with rsp_err=0, rsp_rdt=0.
REQ-019 Read cmd adr=1, ack after 4 cycles with m_mb_rdt=0x0280 -> rsp_rdt=0x0280, rsp_err=0; rsp_valid held across 3 cycles of rsp_ready=0.
REQ-020 Read with no ack, TIMEOUT=15 -> rsp_valid with rsp_err=1, rsp_rdt=0 at acceptance+17; boot_err unchanged.
REQ-021 Boot with the responder never acking -> boot_err=1; init_done=1 after 3 timeouts; the following host command is processed normally.
REQ-022 rstb=1 during WAIT of a host read -> all outputs 0 next cycle; boot restarts with the adr 1 write; no rsp_valid for the abandoned read.

Source files
------------

// File: rtl/median_filter_conf_host.sv
// Host-to-register-bus bridge for the median filter: one outstanding transaction, per-transaction
// timeout, and an optional three-write boot sequence that programs image size and enable.
module median_filter_conf_host #(
  parameter int unsigned DW_MA   = 8,
  parameter int unsigned DW_MD   = 16,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned INIT_EN = 1,
  parameter int unsigned INIT_IW = 640,
  parameter int unsigned INIT_IH = 480
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_wr,
  input  logic [DW_MA-1:0] cmd_adr,
  input  logic [DW_MD-1:0] cmd_wdt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DW_MD-1:0] rsp_rdt,
  output logic             rsp_err,
  output logic [DW_MA-1:0] m_mb_adr,
  output logic [DW_MD-1:0] m_mb_wdt,
  output logic             m_mb_wr,
  output logic             m_mb_rd,
  input  logic [DW_MD-1:0] m_mb_rdt,
  input  logic             m_mb_val,
  output logic             init_done,
  output logic             boot_err
);

  localparam int unsigned ToEff = (TIMEOUT > 1) ? TIMEOUT : 2;
  localparam int unsigned CntW  = $clog2(ToEff);
  localparam logic [CntW-1:0] CntLast = CntW'(ToEff - 1);

  typedef enum logic [2:0] {StBoot, StIdle, StReq, StWait, StResp} state_e;

  state_e           state_q, state_d;
  logic [1:0]       step_q, step_d;
  logic             boot_q, boot_d;
  logic             wr_q, wr_d;
  logic [DW_MA-1:0] adr_q, adr_d;
  logic [DW_MD-1:0] wdt_q, wdt_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             ack_q, ack_d;
  logic [DW_MD-1:0] ack_rdt_q, ack_rdt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [DW_MD-1:0] rsp_rdt_q, rsp_rdt_d;
  logic             rsp_err_q, rsp_err_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             init_done_q, init_done_d;
  logic             boot_err_q, boot_err_d;

  logic             cpl;
  logic             cpl_err;
  logic [DW_MD-1:0] cpl_rdt;

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    boot_d      = boot_q;
    wr_d        = wr_q;
    adr_d       = adr_q;
    wdt_d       = wdt_q;
    cnt_d       = cnt_q;
    ack_d       = ack_q;
    ack_rdt_d   = ack_rdt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdt_d   = rsp_rdt_q;
    rsp_err_d   = rsp_err_q;
    init_done_d = init_done_q;
    boot_err_d  = boot_err_q;
    cpl         = 1'b0;
    cpl_err     = 1'b0;
    cpl_rdt     = '0;

    case (state_q)
      StBoot: begin
        boot_d  = 1'b1;
        wr_d    = 1'b1;
        state_d = StReq;
        case (step_q)
          2'd0: begin
            adr_d = DW_MA'(1);
            wdt_d = DW_MD'(INIT_IW);
          end
          2'd1: begin
            adr_d = DW_MA'(2);
            wdt_d = DW_MD'(INIT_IH);
          end
          default: begin
            adr_d = DW_MA'(0);
            wdt_d = DW_MD'(1);
          end
        endcase
      end
      StIdle: begin
        if (cmd_valid && cmd_ready_q) begin
          boot_d  = 1'b0;
          wr_d    = cmd_wr;
          adr_d   = cmd_adr;
          wdt_d   = cmd_wdt;
          state_d = StReq;
        end
      end
      StReq: begin
        // An ack alongside the strobe is remembered and retired on the first WAIT cycle.
        cnt_d     = '0;
        ack_d     = m_mb_val;
        ack_rdt_d = m_mb_rdt;
        state_d   = StWait;
      end
      StWait: begin
        if (ack_q || m_mb_val) begin
          cpl = 1'b1;
          if (!wr_q) begin
            cpl_rdt = ack_q ? ack_rdt_q : m_mb_rdt;
          end
        end else if (cnt_q == CntLast) begin
          cpl     = 1'b1;
          cpl_err = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (cpl) begin
      ack_d = 1'b0;
      if (boot_q) begin
        boot_err_d = boot_err_q | cpl_err;
        if (step_q == 2'd2) begin
          init_done_d = 1'b1;
          state_d     = StIdle;
        end else begin
          step_d  = step_q + 2'd1;
          state_d = StBoot;
        end
      end else begin
        rsp_valid_d = 1'b1;
        rsp_rdt_d   = cpl_rdt;
        rsp_err_d   = cpl_err;
        state_d     = StResp;
      end
    end

    if (INIT_EN == 0) begin
      init_done_d = 1'b1;
    end
    // Registered so it is 0 throughout reset and low in the RESP handoff cycle.
    cmd_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      state_q     <= (INIT_EN != 0) ? StBoot : StIdle;
      step_q      <= '0;
      boot_q      <= 1'b0;
      wr_q        <= 1'b0;
      adr_q       <= '0;
      wdt_q       <= '0;
      cnt_q       <= '0;
      ack_q       <= 1'b0;
      ack_rdt_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdt_q   <= '0;
      rsp_err_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
      init_done_q <= 1'b0;
      boot_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      boot_q      <= boot_d;
      wr_q        <= wr_d;
      adr_q       <= adr_d;
      wdt_q       <= wdt_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      ack_rdt_q   <= ack_rdt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdt_q   <= rsp_rdt_d;
      rsp_err_q   <= rsp_err_d;
      cmd_ready_q <= cmd_ready_d;
      init_done_q <= init_done_d;
      boot_err_q  <= boot_err_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdt   = rsp_rdt_q;
  assign rsp_err   = rsp_err_q;
  assign m_mb_adr  = adr_q;
  assign m_mb_wdt  = wdt_q;
  assign m_mb_wr   = (state_q == StReq) & wr_q;
  assign m_mb_rd   = (state_q == StReq) & ~wr_q;
  assign init_done = init_done_q;
  assign boot_err  = boot_err_q;

endmodule

// File: tb/tb_median_filter_conf_host.sv
// Bench for median_filter_conf_host: randomized host traffic against a responder with per-strobe
// ack delays; expectations come from transaction-level latency/data rules.
module tb_median_filter_conf_host;

  localparam int TO = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstb, cmd_valid, cmd_ready, cmd_wr, rsp_valid, rsp_ready, rsp_err;
  logic [7:0]  cmd_adr, m_mb_adr;
  logic [15:0] cmd_wdt, rsp_rdt, m_mb_wdt, m_mb_rdt;
  logic        m_mb_wr, m_mb_rd, m_mb_val, init_done, boot_err;

  median_filter_conf_host dut (
    .clk       (clk),
    .rstb      (rstb),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_wr    (cmd_wr),
    .cmd_adr   (cmd_adr),
    .cmd_wdt   (cmd_wdt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdt   (rsp_rdt),
    .rsp_err   (rsp_err),
    .m_mb_adr  (m_mb_adr),
    .m_mb_wdt  (m_mb_wdt),
    .m_mb_wr   (m_mb_wr),
    .m_mb_rd   (m_mb_rd),
    .m_mb_rdt  (m_mb_rdt),
    .m_mb_val  (m_mb_val),
    .init_done (init_done),
    .boot_err  (boot_err)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Responder: one delay/data entry consumed per strobe; -1 means never ack.
  int          dly[512];
  logic [15:0] dat[512];
  int          dw = 0, dr = 0, rdly = -1, rcnt = 0;
  bit          pend = 0, noise = 0;

  // Expected strobes and responses.
  bit          es_wr[512];
  logic [7:0]  es_adr[512];
  logic [15:0] es_wdt[512];
  int          es_cyc[512];
  int          es_w = 0, es_r = 0;
  int          er_cyc[512];
  logic [15:0] er_rdt[512];
  bit          er_err[512];
  int          er_w = 0, er_r = 0;
  int          exp_init = 0;
  bit          exp_berr = 0;
  bit          prev_valid = 0, prev_init = 0, prev_err = 0;
  logic [15:0] prev_rdt = '0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit acked(input int d);
    return d >= 0 && d <= TO;
  endfunction

  // Cycles from strobe to the completing bus cycle.
  function automatic int done_lat(input int d);
    if (acked(d)) return (d < 1) ? 1 : d;
    return TO;
  endfunction

  task automatic push_strobe(input bit wr, input logic [7:0] a, input logic [15:0] w, input int c);
    es_wr[es_w] = wr;
    es_adr[es_w] = a;
    es_wdt[es_w] = w;
    es_cyc[es_w] = c;
    es_w++;
  endtask

  task automatic responder();
    m_mb_val = 1'b0;
    m_mb_rdt = 16'($urandom);
    if (rstb) begin
      pend = 0;
      dr = dw;
    end else begin
      if (m_mb_wr || m_mb_rd) begin
        pend = 1;
        if (dr < dw) begin
          rdly = dly[dr];
          m_mb_rdt = dat[dr];
          dr++;
        end else begin
          rdly = -1;
        end
        rcnt = rdly;
      end
      if (pend && rdly >= 0) begin
        if (rcnt == 0) begin
          m_mb_val = 1'b1;
          m_mb_rdt = dat[dr-1];
          pend = 0;
        end else begin
          rcnt--;
        end
      end else if (!pend && noise && (cmd_ready || rsp_valid)) begin
        m_mb_val = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic compare();
    bit new_rsp;
    if (rstb) begin
      es_r = es_w;
      er_r = er_w;
      prev_valid = 0;
      prev_init = 0;
      return;
    end
    if (m_mb_wr || m_mb_rd) begin
      check("strobe_expected", int'(es_w > es_r), 1);
      if (es_w > es_r) begin
        check("strobe_cyc", cyc, es_cyc[es_r]);
        check("strobe_kind", int'({m_mb_wr, m_mb_rd}), es_wr[es_r] ? 2 : 1);
        check("strobe_adr", int'(m_mb_adr), int'(es_adr[es_r]));
        check("strobe_wdt", int'(m_mb_wdt), int'(es_wdt[es_r]));
        es_r++;
      end
    end
    new_rsp = rsp_valid && !(prev_valid && !rsp_ready);
    if (new_rsp) begin
      check("rsp_expected", int'(er_w > er_r), 1);
      if (er_w > er_r) begin
        check("rsp_cyc", cyc, er_cyc[er_r]);
        check("rsp_rdt", int'(rsp_rdt), int'(er_rdt[er_r]));
        check("rsp_err", int'(rsp_err), int'(er_err[er_r]));
        er_r++;
      end
    end else if (prev_valid && !rsp_ready) begin
      check("rsp_hold_valid", int'(rsp_valid), 1);
      check("rsp_hold_rdt", int'(rsp_rdt), int'(prev_rdt));
      check("rsp_hold_err", int'(rsp_err), int'(prev_err));
    end
    if (init_done && !prev_init) begin
      check("init_cyc", cyc, exp_init);
      check("init_boot_err", int'(boot_err), int'(exp_berr));
    end
    check("ready_excl", int'(cmd_ready && (rsp_valid || !init_done)), 0);
    prev_valid = rsp_valid;
    prev_rdt = rsp_rdt;
    prev_err = rsp_err;
    prev_init = init_done;
  endtask

  // Advance one clock: responder drives after the edge, outputs compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    cyc++;
    #1;
    responder();
    @(negedge clk);
    compare();
  endtask

  task automatic do_boot(input int d0, input int d1, input int d2, output int rel, output int icyc);
    int          d[3];
    logic [7:0]  ba[3];
    logic [15:0] bw[3];
    int          s;
    int          n = 0;
    d[0] = d0;
    d[1] = d1;
    d[2] = d2;
    ba = '{8'd1, 8'd2, 8'd0};
    bw = '{16'd640, 16'd480, 16'd1};
    rstb = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    cycle();
    check("rst_ctl", int'({cmd_ready, rsp_valid, rsp_err, m_mb_wr, m_mb_rd, init_done, boot_err}), 0);
    check("rst_rdt", int'(rsp_rdt), 0);
    check("rst_adr", int'(m_mb_adr), 0);
    check("rst_wdt", int'(m_mb_wdt), 0);
    cycle();
    s = cyc + 1;
    exp_berr = 0;
    for (int k = 0; k < 3; k++) begin
      dly[dw] = d[k];
      dat[dw] = 16'($urandom);
      dw++;
      push_strobe(1'b1, ba[k], bw[k], s);
      if (!acked(d[k])) exp_berr = 1;
      if (k < 2) s = s + done_lat(d[k]) + 2;
      else exp_init = s + done_lat(d[k]) + 1;
    end
    rel = cyc;
    rstb = 1'b0;
    while (!init_done && n < 300) begin
      cycle();
      n++;
    end
    icyc = cyc;
    check("boot_done", int'(init_done), 1);
    check("boot_strobes_seen", es_r, es_w);
    check("boot_err", int'(boot_err), int'(exp_berr));
  endtask

  task automatic host_issue(input bit wr, input logic [7:0] a, input logic [15:0] w, input int d,
                            input logic [15:0] data, output int acc);
    int n = 0;
    while (!cmd_ready && n < 100) begin
      cycle();
      n++;
    end
    check("cmd_ready_seen", int'(cmd_ready), 1);
    dly[dw] = d;
    dat[dw] = data;
    dw++;
    acc = cyc;
    push_strobe(wr, a, w, acc + 1);
    er_cyc[er_w] = acc + 2 + done_lat(d);
    er_rdt[er_w] = (!wr && acked(d)) ? data : 16'h0000;
    er_err[er_w] = !acked(d);
    er_w++;
    cmd_valid = 1'b1;
    cmd_wr = wr;
    cmd_adr = a;
    cmd_wdt = w;
    cycle();
    cmd_valid = 1'b0;
    cmd_wr = 1'($urandom);
    cmd_adr = 8'($urandom);
    cmd_wdt = 16'($urandom);
  endtask

  task automatic host_finish(input int hold, output int rcyc, output logic [15:0] rdt,
                             output logic err);
    int n = 0;
    while (!rsp_valid && n < 40) begin
      cycle();
      n++;
    end
    check("rsp_seen", int'(rsp_valid), 1);
    rcyc = cyc;
    rdt = rsp_rdt;
    err = rsp_err;
    repeat (hold) cycle();
    rsp_ready = 1'b1;
    cycle();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int          rel, icyc, acc, rc, d, h, g;
    logic [15:0] rd;
    logic        er;
    rstb = 1'b1;
    cmd_valid = 1'b0;
    cmd_wr = 1'b0;
    cmd_adr = '0;
    cmd_wdt = '0;
    rsp_ready = 1'b0;
    m_mb_val = 1'b0;
    m_mb_rdt = '0;

    do_boot(2, 2, 2, rel, icyc);
    check("boot_init_lat", icyc - rel, 12);

    host_issue(1'b1, 8'd2, 16'h01E0, 0, 16'h0000, acc);
    host_finish(0, rc, rd, er);
    check("wr0_lat", rc - acc, 3);
    check("wr0_err", int'(er), 0);
    check("wr0_rdt", int'(rd), 0);

    host_issue(1'b0, 8'd1, 16'h0000, 4, 16'h0280, acc);
    host_finish(3, rc, rd, er);
    check("rd4_lat", rc - acc, 6);
    check("rd4_rdt", int'(rd), 16'h0280);
    check("rd4_err", int'(er), 0);

    host_issue(1'b0, 8'd5, 16'h0000, -1, 16'hBEEF, acc);
    host_finish(1, rc, rd, er);
    check("to_lat", rc - acc, 17);
    check("to_err", int'(er), 1);
    check("to_rdt", int'(rd), 0);
    check("to_boot_err", int'(boot_err), 0);

    noise = 1;
    for (int i = 0; i < 40; i++) begin
      d = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 17));
      h = int'($urandom_range(0, 3));
      g = int'($urandom_range(0, 2));
      host_issue(1'($urandom), 8'($urandom), 16'($urandom), d, 16'($urandom), acc);
      host_finish(h, rc, rd, er);
      repeat (g) cycle();
    end

    // Reset in the middle of a read's WAIT phase.
    host_issue(1'b0, 8'h33, 16'h0000, -1, 16'h1234, acc);
    repeat (4) cycle();
    do_boot(1, 1, 1, rel, icyc);
    check("reboot_init_lat", icyc - rel, 9);

    do_boot(-1, -1, -1, rel, icyc);
    check("deadboot_init_lat", icyc - rel, 51);
    check("deadboot_err", int'(boot_err), 1);

    host_issue(1'b0, 8'd2, 16'h0000, 3, 16'h5A5A, acc);
    host_finish(0, rc, rd, er);
    check("post_rd_lat", rc - acc, 5);
    check("post_rd_rdt", int'(rd), 16'h5A5A);
    check("post_rd_err", int'(er), 0);
    check("post_boot_err", int'(boot_err), 1);
    repeat (3) cycle();
    check("all_rsp_seen", er_r, er_w);
    check("all_strobes_seen", es_r, es_w);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
